// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding controller: tracks in-flight destinations in STAGES slots after decode.
// Optional feature: define PIPE_HAZARD_FWD_EN to enable forwarding; otherwise any match stalls.
module pipe_hazard_opnd #(
  parameter int STAGES   = 2,
  parameter int LOAD_LAT = 2,
  parameter int REG_AW   = 5,
  parameter int SEL_W    = 2
) (
  input  logic                           en,
  input  logic [REG_AW-1:0]              rs,
  input  logic [STAGES-1:0]              s_vld,
  input  logic [STAGES-1:0]              s_wen,
  input  logic [STAGES-1:0]              s_ld,
  input  logic [STAGES-1:0][REG_AW-1:0]  s_rd,
  output logic [SEL_W-1:0]               sel,
  output logic                           hazard
);
  logic [SEL_W-1:0] win;
  logic             hit;
  logic             win_ld;

  // Scan oldest to youngest so the youngest matching producer is left in win.
  always_comb begin
    win    = '0;
    hit    = 1'b0;
    win_ld = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (en && s_vld[k-1] && s_wen[k-1] && (s_rd[k-1] == rs)) begin
        win    = SEL_W'(k);
        hit    = 1'b1;
        win_ld = s_ld[k-1];
      end
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  assign sel    = win;
  assign hazard = hit && win_ld && (win < SEL_W'(LOAD_LAT));
`else
  logic unused_fwd;
  assign unused_fwd = ^{win, win_ld, (LOAD_LAT != 0)};
  assign sel    = '0;
  assign hazard = hit;
`endif
endmodule

module pipe_hazard_ctrl #(
  parameter int STAGES   = 2,
  parameter int LOAD_LAT = 2,
  parameter int REG_AW   = 5,
  parameter int COUNT_W  = 32,
  parameter int SEL_W    = $clog2(STAGES+1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic               id_rs1_used,
  input  logic               id_rs2_used,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic               id_rd_wen,
  input  logic               id_is_load,
  input  logic               ex_redirect,
  input  logic               mem_busy,
  output logic               stall_if,
  output logic               bubble_ex,
  output logic               flush_id,
  output logic [SEL_W-1:0]   fwd_rs1_sel,
  output logic [SEL_W-1:0]   fwd_rs2_sel,
  output logic [COUNT_W-1:0] hz_stall_cnt,
  output logic [COUNT_W-1:0] redirect_cnt
);
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              is_load;
  } slot_t;

  slot_t [STAGES:1] slot;

  logic [STAGES-1:0]             s_vld, s_wen, s_ld;
  logic [STAGES-1:0][REG_AW-1:0] s_rd;

  for (genvar k = 1; k <= STAGES; k++) begin : g_unpack
    assign s_vld[k-1] = slot[k].valid;
    assign s_wen[k-1] = slot[k].wen;
    assign s_ld[k-1]  = slot[k].is_load;
    assign s_rd[k-1]  = slot[k].rd;
  end

  logic [1:0]             op_en, op_hz;
  logic [1:0][REG_AW-1:0] op_rs;
  logic [1:0][SEL_W-1:0]  op_sel;
  logic                   lu;

  assign op_rs = {id_rs2, id_rs1};
  assign op_en = {id_valid && id_rs2_used && (id_rs2 != '0),
                  id_valid && id_rs1_used && (id_rs1 != '0)};
  assign lu    = |op_hz;

  pipe_hazard_opnd #(
    .STAGES(STAGES), .LOAD_LAT(LOAD_LAT), .REG_AW(REG_AW), .SEL_W(SEL_W)
  ) u_opnd [1:0] (
    .en(op_en), .rs(op_rs), .s_vld(s_vld), .s_wen(s_wen), .s_ld(s_ld), .s_rd(s_rd),
    .sel(op_sel), .hazard(op_hz)
  );

  // Freeze outranks redirect, which outranks load-use; reset forces everything quiet.
  always_comb begin
    stall_if    = 1'b0;
    bubble_ex   = 1'b0;
    flush_id    = 1'b0;
    fwd_rs1_sel = op_sel[0];
    fwd_rs2_sel = op_sel[1];
    if (rst) begin
      fwd_rs1_sel = '0;
      fwd_rs2_sel = '0;
    end else if (mem_busy) begin
      stall_if = 1'b1;
    end else if (ex_redirect) begin
      flush_id = 1'b1;
    end else if (lu) begin
      stall_if  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot         <= '0;
      hz_stall_cnt <= '0;
      redirect_cnt <= '0;
    end else if (!mem_busy) begin
      if (ex_redirect || lu) slot[1] <= '0;
      else slot[1] <= '{valid: id_valid, rd: id_rd, wen: id_rd_wen, is_load: id_is_load};
      for (int k = 2; k <= STAGES; k++) slot[k] <= slot[k-1];
      if (ex_redirect)  redirect_cnt <= redirect_cnt + 1'b1;
      else if (lu)      hz_stall_cnt <= hz_stall_cnt + 1'b1;
    end
  end
endmodule
